// File: rtl/des_ctrl_pkg.sv
// des_ctrl_pkg: shared opcodes, FSM states and width helpers for the 3DES command sequencer.
package des_ctrl_pkg;

    // Default geometry: 8-byte blocks and keys, three key slots (3DES).
    localparam int BLK_BYTES_DEF = 8;
    localparam int NUM_KEYS_DEF  = 3;

    // Key-slot select width; a single-slot build still gets a 1-bit select.
    function automatic int ksel_width(input int num_keys);
        return (num_keys > 1) ? $clog2(num_keys) : 1;
    endfunction

    localparam int CNT_W  = $clog2(BLK_BYTES_DEF + 1);
    localparam int KSEL_W = ksel_width(NUM_KEYS_DEF);

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_LOAD_KEY  = 3'd1,
        CMD_LOAD_DATA = 3'd2,
        CMD_ENCRYPT   = 3'd3,
        CMD_DECRYPT   = 3'd4,
        CMD_CLEAR     = 3'd5,
        CMD_UNLOAD    = 3'd6,
        CMD_RSVD      = 3'd7
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_KEY,
        ST_LD_DATA,
        ST_START,
        ST_RUN,
        ST_UNLOAD,
        ST_CLEAR
    } state_e;

endpackage

// File: rtl/byte_cnt.sv
// byte_cnt: saturating up/down byte counter with synchronous clear and parallel load.
module byte_cnt #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    // Clear wins over load, load over inc/dec; the count never passes MAX or drops below 0.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (ld) begin
            count <= ld_val;
        end else if (inc && !dec && (count < W'(MAX))) begin
            count <= count + W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/des_ctrl_seq.sv
// des_ctrl_seq: host command sequencer for the 3DES accelerator. Loads key slots and the
// data block byte-wise, starts the core, waits for completion and streams the result out.
// Optional core-completion watchdog: define DES_CTRL_WDOG_EN.
module des_ctrl_seq
    import des_ctrl_pkg::*;
#(
    parameter int BLK_BYTES   = BLK_BYTES_DEF,
    parameter int NUM_KEYS    = NUM_KEYS_DEF,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [2:0]                      cmd,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            byte_valid,
    input  logic                            out_ready,
    output logic                            shift_in,
    output logic                            key_load,
    output logic [ksel_width(NUM_KEYS)-1:0] key_sel,
    output logic                            shift_out,
    output logic                            core_start,
    output logic                            core_decrypt,
    input  logic                            core_done,
    output logic [$clog2(BLK_BYTES+1)-1:0]  in_count,
    output logic [$clog2(BLK_BYTES+1)-1:0]  out_count,
    output logic                            in_clear,
    output logic                            out_clear,
    output logic                            busy,
    output logic                            err
);

    localparam int CW = $clog2(BLK_BYTES + 1);
    localparam int KW = ksel_width(NUM_KEYS);

    // Reject nonsensical geometry at elaboration time.
    if (BLK_BYTES < 1 || NUM_KEYS < 1 || WDOG_CYCLES < 1) begin : g_param_check
        $error("des_ctrl_seq: BLK_BYTES, NUM_KEYS and WDOG_CYCLES must all be at least 1");
    end

    state_e              state;
    cmd_e                cmd_op;
    logic [NUM_KEYS-1:0] keys_valid;
    logic                data_full;
    logic                load_accept;
    logic                in_last;
    logic                wdog_expired;

    assign cmd_op = cmd_e'(cmd);

    // Outputs decoded straight from the state register; shift strobes follow their inputs.
    assign cmd_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign key_load   = (state == ST_LD_KEY);
    assign shift_in   = byte_valid && ((state == ST_LD_KEY) || (state == ST_LD_DATA));
    assign shift_out  = out_ready && (state == ST_UNLOAD);
    assign core_start = (state == ST_START);
    assign in_clear   = (state == ST_CLEAR);
    assign out_clear  = (state == ST_CLEAR);

    // Accepting either load command restarts the input byte count from zero.
    assign load_accept = cmd_valid && cmd_ready &&
                         ((cmd_op == CMD_LOAD_KEY) || (cmd_op == CMD_LOAD_DATA));
    assign in_last     = byte_valid && (in_count == CW'(BLK_BYTES - 1));

    byte_cnt #(.W(CW), .MAX(BLK_BYTES)) u_in_cnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (load_accept || (state == ST_CLEAR)),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (shift_in),
        .dec    (1'b0),
        .count  (in_count)
    );

    byte_cnt #(.W(CW), .MAX(BLK_BYTES)) u_out_cnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (state == ST_CLEAR),
        .ld     ((state == ST_RUN) && core_done),
        .ld_val (CW'(BLK_BYTES)),
        .inc    (1'b0),
        .dec    (shift_out),
        .count  (out_count)
    );

`ifdef DES_CTRL_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt;

    // Count cycles spent in RUN; restarts every time RUN is entered.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wdog_cnt <= '0;
        end else if (state != ST_RUN) begin
            wdog_cnt <= '0;
        end else if (!wdog_expired) begin
            wdog_cnt <= wdog_cnt + WW'(1);
        end
    end

    assign wdog_expired = (wdog_cnt == WW'(WDOG_CYCLES - 1));
`else
    assign wdog_expired = 1'b0;
`endif

    // Main sequencer: command decode, load completion, core handshake and unload.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= ST_IDLE;
            key_sel      <= '0;
            keys_valid   <= '0;
            data_full    <= 1'b0;
            core_decrypt <= 1'b0;
            err          <= 1'b0;
        end else begin
            // A completion pulse the core sends while we are not waiting for one is a protocol error.
            err <= core_done && (state != ST_RUN);
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        unique case (cmd_op)
                            CMD_LOAD_KEY:  state <= ST_LD_KEY;
                            CMD_LOAD_DATA: begin
                                state     <= ST_LD_DATA;
                                data_full <= 1'b0;
                            end
                            CMD_ENCRYPT, CMD_DECRYPT: begin
                                if (data_full && (&keys_valid)) begin
                                    core_decrypt <= (cmd_op == CMD_DECRYPT);
                                    state        <= ST_START;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            CMD_CLEAR:     state <= ST_CLEAR;
                            CMD_UNLOAD: begin
                                if (out_count != '0) begin
                                    state <= ST_UNLOAD;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            CMD_RSVD:      err <= 1'b1;
                            default:       ;
                        endcase
                    end
                end
                ST_LD_KEY: begin
                    if (in_last) begin
                        keys_valid[key_sel] <= 1'b1;
                        key_sel <= (key_sel == KW'(NUM_KEYS - 1)) ? '0 : key_sel + KW'(1);
                        state   <= ST_IDLE;
                    end
                end
                ST_LD_DATA: begin
                    if (in_last) begin
                        data_full <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_START: state <= ST_RUN;
                ST_RUN: begin
                    if (core_done) begin
                        data_full <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (wdog_expired) begin
                        err   <= 1'b1;
                        state <= ST_CLEAR;
                    end
                end
                ST_UNLOAD: begin
                    if (out_ready && (out_count == CW'(1))) begin
                        state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    key_sel    <= '0;
                    keys_valid <= '0;
                    data_full  <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_ctrl_seq.sv
// tb_des_ctrl_seq: directed sequence with randomized timing for des_ctrl_seq, checked
// against a transaction-level model of key slots, data block and output bytes.
module tb_des_ctrl_seq;
    import des_ctrl_pkg::*;

    localparam int BLK = BLK_BYTES_DEF;
    localparam int NK  = NUM_KEYS_DEF;

    logic              clk;
    logic              n_rst;
    logic [2:0]        cmd;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              byte_valid;
    logic              out_ready;
    logic              shift_in;
    logic              key_load;
    logic [KSEL_W-1:0] key_sel;
    logic              shift_out;
    logic              core_start;
    logic              core_decrypt;
    logic              core_done;
    logic [CNT_W-1:0]  in_count;
    logic [CNT_W-1:0]  out_count;
    logic              in_clear;
    logic              out_clear;
    logic              busy;
    logic              err;

    des_ctrl_seq dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .byte_valid   (byte_valid),
        .out_ready    (out_ready),
        .shift_in     (shift_in),
        .key_load     (key_load),
        .key_sel      (key_sel),
        .shift_out    (shift_out),
        .core_start   (core_start),
        .core_decrypt (core_decrypt),
        .core_done    (core_done),
        .in_count     (in_count),
        .out_count    (out_count),
        .in_clear     (in_clear),
        .out_clear    (out_clear),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks    = 0;
    int n_errors    = 0;
    int n_shift_in  = 0;
    int n_shift_out = 0;

    // Reference model: which key slots hold a key, which slot loads next, whether a data
    // block is waiting, bytes of the current load and result bytes still to stream out.
    bit key_ok [NK];
    int m_slot;
    bit m_data_full;
    int m_in;
    int m_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (key_ok[i]) key_ok[i] = 1'b0;
        m_slot      = 0;
        m_data_full = 1'b0;
        m_in        = 0;
        m_out       = 0;
    endtask

    function automatic bit all_keys();
        bit ok = 1'b1;
        foreach (key_ok[i]) ok &= key_ok[i];
        return ok;
    endfunction

    function automatic bit pred_err(input logic [2:0] c);
        case (c)
            3'd3, 3'd4: return !(m_data_full && all_keys());
            3'd6:       return (m_out == 0);
            3'd7:       return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_quiet(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_core_start"}, core_start, 1'b0);
        check({tag, "_key_load"}, key_load, 1'b0);
        check({tag, "_in_clear"}, in_clear, 1'b0);
        check({tag, "_out_clear"}, out_clear, 1'b0);
    endtask

    // Present one command in IDLE for a single cycle and check the err response.
    task automatic issue(input logic [2:0] c);
        bit e;
        e         = pred_err(c);
        cmd       = c;
        cmd_valid = 1'b1;
        #1;
        check($sformatf("cmd_ready_before_cmd%0d", c), cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        check($sformatf("err_cmd%0d", c), err, e);
        if (!e && (c == 3'd1 || c == 3'd2)) begin
            m_in = 0;
            if (c == 3'd2) m_data_full = 1'b0;
            check($sformatf("in_count_start_cmd%0d", c), in_count, 0);
        end
    endtask

    // Feed n byte strobes with random gaps into the load in progress.
    task automatic feed(input bit is_key, input int n);
        int sent = 0;
        int cyc  = 0;
        while (sent < n) begin
            byte_valid = (cyc > 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            check("shift_in", shift_in, byte_valid);
            check("key_load", key_load, is_key);
            if (is_key) check("key_sel_during_load", key_sel, m_slot);
            if (shift_in) n_shift_in++;
            tick();
            if (byte_valid) begin
                sent++;
                m_in++;
                if (m_in == BLK) begin
                    if (is_key) begin
                        key_ok[m_slot] = 1'b1;
                        m_slot = (m_slot + 1) % NK;
                    end else begin
                        m_data_full = 1'b1;
                    end
                end
            end
            cyc++;
        end
        byte_valid = 1'b0;
        check("in_count_after_load", in_count, m_in);
        check("busy_after_load", busy, m_in < BLK);
    endtask

    // Start the core in the given direction and answer with core_done after dly RUN cycles.
    task automatic run(input bit dec, input int dly);
        issue(dec ? 3'd4 : 3'd3);
        check("core_start_pulse", core_start, 1'b1);
        check("core_decrypt_at_start", core_decrypt, dec);
        tick();
        check("core_start_one_cycle", core_start, 1'b0);
        repeat (dly) begin
            check("busy_in_run", busy, 1'b1);
            check("core_start_quiet_in_run", core_start, 1'b0);
            tick();
        end
        core_done = 1'b1;
        #1;
        check("core_decrypt_held", core_decrypt, dec);
        tick();
        core_done   = 1'b0;
        m_out       = BLK;
        m_data_full = 1'b0;
        check("out_count_after_done", out_count, m_out);
        check("busy_after_done", busy, 1'b0);
        check("err_after_done", err, 1'b0);
    endtask

    // Stream result bytes with a random out_ready pattern until stop_at bytes remain.
    task automatic unload(input int stop_at);
        int cyc = 0;
        issue(3'd6);
        while (m_out > stop_at && cyc < 200) begin
            out_ready = ($urandom_range(0, 1) != 0);
            #1;
            check("shift_out", shift_out, out_ready);
            if (shift_out) n_shift_out++;
            tick();
            if (out_ready) m_out--;
            cyc++;
        end
        out_ready = 1'b0;
        check("out_count_after_unload", out_count, m_out);
        check("busy_after_unload", busy, m_out != 0);
    endtask

    task automatic do_clear();
        issue(3'd5);
        check("in_clear_pulse", in_clear, 1'b1);
        check("out_clear_pulse", out_clear, 1'b1);
        check("cmd_ready_in_clear", cmd_ready, 1'b0);
        tick();
        model_reset();
        check("in_count_cleared", in_count, m_in);
        check("out_count_cleared", out_count, m_out);
        check("key_sel_cleared", key_sel, m_slot);
        check_idle_quiet("after_clear");
    endtask

    initial begin
        int base;
        n_rst      = 1'b0;
        cmd        = 3'd0;
        cmd_valid  = 1'b0;
        byte_valid = 1'b0;
        out_ready  = 1'b0;
        core_done  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Reset state.
        check_idle_quiet("reset");
        check("reset_shift_in", shift_in, 1'b0);
        check("reset_shift_out", shift_out, 1'b0);
        check("reset_key_sel", key_sel, 0);
        check("reset_core_decrypt", core_decrypt, 1'b0);
        check("reset_in_count", in_count, 0);
        check("reset_out_count", out_count, 0);
        check("reset_err", err, 1'b0);
        n_rst = 1'b1;
        tick();

        // Start without keys or data, reserved opcode, NOP.
        issue(3'd3);
        check("busy_after_bad_start", busy, 1'b0);
        tick();
        check("err_single_cycle", err, 1'b0);
        issue(3'd7);
        issue(3'd0);
        check("busy_after_nop", busy, 1'b0);

        // Three key loads, key_sel walks 0,1,2 and wraps to 0.
        for (int k = 0; k < NK; k++) begin
            check($sformatf("key_sel_seq_%0d", k), key_sel, k);
            issue(3'd1);
            feed(1'b1, BLK);
        end
        check("key_sel_wrap", key_sel, m_slot);
        issue(3'd4);
        issue(3'd2);
        feed(1'b0, BLK);
        check("shift_in_total", n_shift_in, (NK + 1) * BLK);

        // Byte strobes outside a load are ignored and the count saturates.
        byte_valid = 1'b1;
        #1;
        check("shift_in_ignored_idle", shift_in, 1'b0);
        tick();
        byte_valid = 1'b0;
        check("in_count_saturated", in_count, BLK);

        // Decrypt with core_done ten cycles into RUN.
        run(1'b1, 10);
        out_ready = 1'b1;
        #1;
        check("shift_out_ignored_idle", shift_out, 1'b0);
        tick();
        out_ready = 1'b0;
        check("out_count_held_idle", out_count, BLK);
        issue(3'd3);

        // Stray core completion in IDLE.
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("err_stray_core_done", err, 1'b1);
        tick();
        check("err_stray_clears", err, 1'b0);

        // Full unload, then an unload with nothing left.
        base = n_shift_out;
        unload(0);
        check("shift_out_total", n_shift_out - base, BLK);
        issue(3'd6);

        // Partial data load with a command held while busy.
        issue(3'd2);
        feed(1'b0, 5);
        cmd       = 3'd3;
        cmd_valid = 1'b1;
        repeat (6) begin
            #1;
            check("cmd_ready_while_busy", cmd_ready, 1'b0);
            tick();
            check("no_err_while_busy", err, 1'b0);
            check("in_count_holds", in_count, 5);
        end
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        feed(1'b0, BLK - 5);

        // Random encrypt/decrypt rounds.
        repeat (4) begin
            run($urandom_range(0, 1) != 0, $urandom_range(0, 20));
            unload(0);
            issue(3'd2);
            feed(1'b0, BLK);
        end

        // Asynchronous reset in the middle of an unload.
        run(1'b0, $urandom_range(1, 12));
        unload(3);
        check("out_count_before_reset", out_count, 3);
        out_ready = 1'b1;
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_idle_quiet("async_reset");
        check("async_reset_shift_out", shift_out, 1'b0);
        check("async_reset_out_count", out_count, m_out);
        check("async_reset_in_count", in_count, m_in);
        check("async_reset_key_sel", key_sel, m_slot);
        check("async_reset_core_decrypt", core_decrypt, 1'b0);
        check("async_reset_err", err, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) begin
            check("no_core_start_after_reset", core_start, 1'b0);
            tick();
        end
        issue(3'd6);
        issue(3'd3);

        // CLEAR wipes key slots, data and counters.
        issue(3'd1);
        feed(1'b1, BLK);
        issue(3'd2);
        feed(1'b0, BLK);
        do_clear();
        issue(3'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/des_ctrl_seq.md
Name: des_ctrl_seq

Overview:
- Parametrised command sequencer for the 3DES accelerator.
- Accepts host commands over a valid/ready handshake and sequences byte-wise loading of key slots and the data block into the input shift registers.
- Starts the cipher core, waits for its completion, and streams the result out of the output shift register.
- Replaces the flat mode decoder with a real FSM, per-slot key tracking, error reporting and a core handshake.

Parameters:
- BLK_BYTES, 8, bytes per data block and per key.
- NUM_KEYS, 3, number of key slots (1 = single DES, 3 = 3DES).
- WDOG_CYCLES, 64, core-completion timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- cmd  in  3  opcode: 0 NOP, 1 LOAD_KEY, 2 LOAD_DATA, 3 ENCRYPT, 4 DECRYPT, 5 CLEAR, 6 UNLOAD, 7 reserved.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- byte_valid  in  1  input byte strobe during loads.
- out_ready  in  1  consumer takes one output byte.
- shift_in  out  1  shift enable for the input register (data or key).
- key_load  out  1  qualifies shift_in as a key byte.
- key_sel  out  $clog2(NUM_KEYS) max 1  key slot being loaded.
- shift_out  out  1  shift enable for the output register.
- core_start  out  1  one-cycle start pulse to the core.
- core_decrypt  out  1  direction, held stable from start until done.
- core_done  in  1  core completion pulse.
- in_count  out  $clog2(BLK_BYTES+1)  bytes of the current load.
- out_count  out  $clog2(BLK_BYTES+1)  output bytes remaining.
- in_clear, out_clear  out  1  one-cycle register clear pulses.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle protocol error pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, key_sel 0, keys_valid mask 0, data_full 0. Exception: cmd_ready = 1 after reset.
- FSM states: IDLE, LD_KEY, LD_DATA, START, RUN, UNLOAD, CLEAR. A command is accepted when cmd_valid and cmd_ready are both high.
- IDLE, cmd 1 -> LD_KEY, in_count = 0. cmd 2 -> LD_DATA, in_count = 0, data_full = 0. cmd 5 -> CLEAR. NOP and 7 are ignored; 7 pulses err.
- LD_KEY / LD_DATA:
  - Each cycle with byte_valid: shift_in = 1 combinationally, in_count + 1.
  - key_load = 1 throughout LD_KEY.
  - On the cycle in_count reaches BLK_BYTES -> IDLE.
  - LD_DATA completion sets data_full.
  - LD_KEY completion sets keys_valid[key_sel] and advances key_sel, wrapping NUM_KEYS-1 -> 0.
- cmd 3/4:
  - Accepted only when data_full = 1 and all keys are valid; otherwise err pulse and stay IDLE.
  - On acceptance: core_decrypt = (cmd == 4), next state START.
  - START: core_start = 1 for exactly one cycle -> RUN.
  - RUN: wait for core_done, then out_count = BLK_BYTES, data_full = 0, -> IDLE.
  - core_done outside RUN: ignored, err pulse.
- cmd 6:
  - If out_count = 0: err, stay IDLE.
  - Otherwise -> UNLOAD. Each cycle with out_ready: shift_out = 1, out_count - 1; at 0 -> IDLE.
- CLEAR (one cycle): in_clear = out_clear = 1, in_count = out_count = 0, key_sel = 0, keys_valid = 0, data_full = 0 -> IDLE.
- Commands arriving while busy are not accepted (cmd_ready = 0) and are not errors.
- byte_valid outside load states and out_ready outside UNLOAD are ignored.
- Counters never wrap: in_count saturates at BLK_BYTES, out_count saturates at 0.
- Asynchronous reset mid-operation aborts to the reset state. No core_start is issued afterwards.

Optional Feature:
- Macro DES_CTRL_WDOG_EN.
- Defined: a RUN cycle counter. If core_done has not arrived after WDOG_CYCLES cycles:
  - err pulse;
  - state goes to CLEAR;
  - out_count stays 0.
- Undefined: RUN waits indefinitely. No counter logic is synthesised; WDOG_CYCLES is unused.

Decomposition:
- Package des_ctrl_pkg: cmd_e opcode enum (values 0-7), state_e FSM enum, localparams CNT_W = $clog2(BLK_BYTES+1) and KSEL_W.
- Sub-module byte_cnt: parametrised saturating up/down counter with clear. Instantiated twice, once for in_count and once for out_count.

Test Plan:
- Reset -> cmd_ready = 1, all other outputs 0. Then cmd 3 -> err pulse, state remains IDLE.
- Three LOAD_KEY with 8 byte_valid each, then LOAD_DATA with 8 bytes:
  - -> 32 shift_in pulses;
  - key_sel sequence 0, 1, 2, 0;
  - in_count 8 at end of each load.
- Full load, then cmd 4 -> core_start high for one cycle with core_decrypt = 1. core_done 10 cycles later -> out_count = 8. UNLOAD with out_ready toggling 50% -> 8 shift_out pulses, back to IDLE.
- LOAD_DATA with only 5 bytes, then cmd_valid with cmd 3 held -> cmd_ready stays 0, in_count holds at 5, no err.
- Mid-UNLOAD at out_count = 3, assert n_rst low -> all outputs 0 immediately. After release, cmd 6 -> err.
- With DES_CTRL_WDOG_EN, WDOG_CYCLES = 64 and no core_done -> err pulse at cycle 64 of RUN, followed by in_clear/out_clear pulse.
